// File: rtl/mask_deserializer.sv
// rtl/mask_deserializer.sv - reassembles interleaved serial mask slices into a double-buffered row
//
// Purpose: accepts one IP_CHANNEL_WIDTH-bit slice per valid cycle and rebuilds a
// full mask row using the serializer's interleaving (lane i, beat k -> bit i*steps+k).
// Completed rows are presented on DOUT with a one-cycle done strobe. DOUT is held
// while the next row is collected.
//
// Ports:
//   clk             - clock, rising edge
//   rst             - asynchronous active-high reset
//   DIN             - serial slice, lane i carries one bit of row segment i
//   valid           - DIN holds a beat this cycle
//   clear           - synchronous abort of the partial row (wins over valid)
//   imageResolution - row length select, sampled on beat 0 only
//   DOUT            - last completed row (unused upper bits zero)
//   done            - one-cycle strobe, DOUT just updated
//   busy            - partial row in progress (registered)
//   res_out         - resolution of the row currently on DOUT
module mask_deserializer #(
  parameter int IP_CHANNEL_WIDTH = 20,
  parameter int OP_CHANNEL_WIDTH = 1080,
  parameter int stepSel0         = 16,
  parameter int stepSel1         = 32,
  parameter int stepSel2         = 54
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IP_CHANNEL_WIDTH-1:0] DIN,
  input  logic                        valid,
  input  logic                        clear,
  input  logic [1:0]                  imageResolution,
  output logic [OP_CHANNEL_WIDTH-1:0] DOUT,
  output logic                        done,
  output logic                        busy,
  output logic [1:0]                  res_out
);

  localparam int CW = $clog2(stepSel2 + 1);
  localparam int IW = $clog2(OP_CHANNEL_WIDTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                      state_q;
  logic [CW-1:0]               count_q;
  logic [CW-1:0]               steps_q;
  logic [1:0]                  row_res_q;
  logic [OP_CHANNEL_WIDTH-1:0] asm_q;

  logic [OP_CHANNEL_WIDTH-1:0] asm_next;
  logic [CW-1:0]               cur_steps;
  logic [1:0]                  cur_res;
  logic [IW-1:0]               bit_idx;
  logic                        last_beat;

  function automatic logic [CW-1:0] steps_for(input logic [1:0] res);
    case (res)
      2'b00:   steps_for = CW'(stepSel0);
      2'b01:   steps_for = CW'(stepSel1);
      default: steps_for = CW'(stepSel2);
    endcase
  endfunction

  // In IDLE the incoming beat starts a new row, so its geometry comes straight
  // from imageResolution; afterwards the latched copy is used so mid-row
  // changes on the input are ignored.
  always_comb begin
    cur_res   = (state_q == IDLE) ? imageResolution : row_res_q;
    cur_steps = (state_q == IDLE) ? steps_for(imageResolution) : steps_q;
    asm_next  = asm_q;
    bit_idx   = '0;
    for (int i = 0; i < IP_CHANNEL_WIDTH; i++) begin
      bit_idx           = IW'(i) * IW'(cur_steps) + IW'(count_q);
      asm_next[bit_idx] = DIN[i];
    end
    last_beat = (count_q == cur_steps - 1'b1);
  end

  // The assembly buffer is zeroed after every row and on clear, and only bits
  // below IP_CHANNEL_WIDTH*steps are ever written, so the upper part of a
  // completed row is guaranteed zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      steps_q   <= '0;
      row_res_q <= 2'b00;
      asm_q     <= '0;
      DOUT      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      res_out   <= 2'b00;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        count_q <= '0;
        asm_q   <= '0;
        busy    <= 1'b0;
      end else if (valid) begin
        if (state_q == IDLE) begin
          row_res_q <= imageResolution;
          steps_q   <= cur_steps;
        end
        if (last_beat) begin
          DOUT    <= asm_next;
          res_out <= cur_res;
          done    <= 1'b1;
          count_q <= '0;
          asm_q   <= '0;
          state_q <= IDLE;
          busy    <= 1'b0;
        end else begin
          asm_q   <= asm_next;
          count_q <= count_q + 1'b1;
          state_q <= COLLECT;
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mask_deserializer.sv
// tb/tb_mask_deserializer.sv - directed self-checking bench for mask_deserializer
module tb_mask_deserializer;

  localparam int IPW = 20;
  localparam int OPW = 1080;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [IPW-1:0] DIN = '0;
  logic           valid = 1'b0;
  logic           clear = 1'b0;
  logic [1:0]     imageResolution = 2'b00;
  logic [OPW-1:0] DOUT;
  logic           done;
  logic           busy;
  logic [1:0]     res_out;

  int checks = 0;
  int failures = 0;

  int done_cnt, done_beat, busy_err;
  logic done_after;

  logic [OPW-1:0] row_r, row_a, row_b, ones320, ones1080;

  mask_deserializer dut (
    .clk(clk), .rst(rst), .DIN(DIN), .valid(valid), .clear(clear),
    .imageResolution(imageResolution), .DOUT(DOUT), .done(done),
    .busy(busy), .res_out(res_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
    int first_bad;
    checks++;
    if (got !== exp) begin
      failures++;
      first_bad = -1;
      for (int b = 0; b < OPW; b++)
        if (first_bad < 0 && got[b] !== exp[b]) first_bad = b;
      $display("FAIL %s: got[63:0]=%h expected[63:0]=%h first_diff_bit=%0d",
               tag, got[63:0], exp[63:0], first_bad);
    end
  endtask

  function automatic int steps_of(input logic [1:0] res);
    case (res)
      2'b00:   steps_of = 16;
      2'b01:   steps_of = 32;
      default: steps_of = 54;
    endcase
  endfunction

  // Serializer model: lane i of beat k carries row bit i*steps+k.
  function automatic logic [IPW-1:0] slice(input logic [OPW-1:0] row, input int s, input int k);
    logic [IPW-1:0] v;
    for (int i = 0; i < IPW; i++) v[i] = row[i*s + k];
    return v;
  endfunction

  task automatic send_row(input logic [OPW-1:0] row, input logic [1:0] res,
                          input int nbeats, input int gap, input bit clr_last);
    int s;
    s = steps_of(res);
    done_cnt = 0; done_beat = 0; busy_err = 0;
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      DIN = slice(row, s, k);
      valid = 1'b1;
      clear = clr_last && (k == nbeats - 1);
      imageResolution = (k == 0) ? res : ~res;
      @(posedge clk); #1;
      if (done) begin done_cnt++; done_beat = k + 1; end
      if (k < s - 1 && !clear && busy !== 1'b1) busy_err++;
      for (int g = 0; g < gap && k < nbeats - 1; g++) begin
        @(negedge clk);
        valid = 1'b0;
        clear = 1'b0;
        @(posedge clk); #1;
        if (done) done_cnt++;
        if (busy !== 1'b1) busy_err++;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
    @(posedge clk); #1;
    done_after = done;
    if (done) done_cnt++;
  endtask

  initial begin
    int d1, d2, npulse;
    logic [OPW-1:0] mid_dout;

    row_r    = '0; row_r[639:0] = {10{64'h0123456789abcdef}};
    row_a    = '0; row_a[639:0] = {20{32'hdeadbeef}};
    row_b    = '0; row_b[639:0] = {10{64'h5a5a_0ff0_c3c3_9669}};
    ones320  = '0; ones320[319:0] = '1;
    ones1080 = '1;

    #1;
    check("reset_dout", DOUT, '0);
    check("reset_done", OPW'(done), '0);
    check("reset_busy", OPW'(busy), '0);
    check("reset_res",  OPW'(res_out), '0);
    #10 rst = 1'b0;

    send_row(row_r, 2'b01, 32, 0, 1'b0);
    check("r640_dout", DOUT, row_r);
    check("r640_res", OPW'(res_out), OPW'(2'b01));
    check("r640_done_cnt", OPW'(done_cnt), OPW'(1));
    check("r640_done_beat", OPW'(done_beat), OPW'(32));
    check("r640_done_fell", OPW'(done_after), '0);
    check("r640_busy_run", OPW'(busy_err), '0);

    send_row(ones1080, 2'b00, 16, 0, 1'b0);
    check("ones320_dout", DOUT, ones320);
    check("ones320_res", OPW'(res_out), OPW'(2'b00));
    check("ones320_done_beat", OPW'(done_beat), OPW'(16));

    send_row(ones1080, 2'b10, 54, 0, 1'b0);
    check("ones1080_dout", DOUT, ones1080);
    check("ones1080_res", OPW'(res_out), OPW'(2'b10));
    check("ones1080_done_beat", OPW'(done_beat), OPW'(54));

    send_row(row_r, 2'b01, 32, 2, 1'b0);
    check("gap_dout", DOUT, row_r);
    check("gap_done_cnt", OPW'(done_cnt), OPW'(1));
    check("gap_busy_run", OPW'(busy_err), '0);
    check("gap_busy_end", OPW'(busy), '0);

    send_row(row_a, 2'b01, 32, 0, 1'b0);
    check("clr_prior_dout", DOUT, row_a);
    send_row(row_b, 2'b01, 10, 0, 1'b0);
    check("clr_partial_busy", OPW'(busy), OPW'(1));
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    check("clr_busy", OPW'(busy), '0);
    check("clr_done", OPW'(done), '0);
    check("clr_dout_kept", DOUT, row_a);
    @(negedge clk); clear = 1'b0;
    send_row(row_b, 2'b01, 32, 0, 1'b0);
    check("clr_next_dout", DOUT, row_b);
    check("clr_next_done_beat", OPW'(done_beat), OPW'(32));
    send_row(row_a, 2'b01, 32, 0, 1'b1);
    check("clr_last_done_cnt", OPW'(done_cnt), '0);
    check("clr_last_dout", DOUT, row_b);
    check("clr_last_busy", OPW'(busy), '0);

    d1 = 0; d2 = 0; npulse = 0; mid_dout = '0;
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      DIN = slice((j < 32) ? row_a : row_b, 32, j % 32);
      valid = 1'b1;
      imageResolution = 2'b01;
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (npulse == 1) d1 = j + 1;
        if (npulse == 2) d2 = j + 1;
      end
      if (j == 40) mid_dout = DOUT;
    end
    @(negedge clk); valid = 1'b0;
    @(posedge clk); #1;
    if (done) npulse++;
    check("b2b_pulses", OPW'(npulse), OPW'(2));
    check("b2b_first", OPW'(d1), OPW'(32));
    check("b2b_second", OPW'(d2), OPW'(64));
    check("b2b_mid_dout", mid_dout, row_a);
    check("b2b_final_dout", DOUT, row_b);

    send_row(row_b, 2'b01, 20, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_dout", DOUT, '0);
    check("rst_busy", OPW'(busy), '0);
    check("rst_res", OPW'(res_out), '0);
    rst = 1'b0;
    send_row(row_r, 2'b01, 32, 0, 1'b0);
    check("rst_fresh_dout", DOUT, row_r);
    check("rst_fresh_done_beat", OPW'(done_beat), OPW'(32));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mask_deserializer.md
# mask_deserializer

Receive-side counterpart of the mask serializer. It accepts one IP_CHANNEL_WIDTH-bit slice per valid cycle from the serial mask channel and reassembles a full mask row in the same interleaved bit order the serializer produces. It then presents the row on a wide, double-buffered output with a one-cycle `done` strobe. It sits between the narrow mask link and the row-wide mask consumers.

## Interface
- IP_CHANNEL_WIDTH, 20: serial slice width (lanes).
- OP_CHANNEL_WIDTH, 1080: row output width; must equal IP_CHANNEL_WIDTH*stepSel2.
- stepSel0, 16: beats per row, imageResolution 2'b00 (320-bit row).
- stepSel1, 32: beats per row, imageResolution 2'b01 (640-bit row).
- stepSel2, 54: beats per row, imageResolution 2'b10 and 2'b11 (1080-bit row).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- DIN  in  IP_CHANNEL_WIDTH  serial slice; lane i carries one bit of row segment i.
- valid  in  1  DIN holds a beat this cycle.
- clear  in  1  synchronous abort; discards the partial row.
- imageResolution  in  2  row length select; sampled on the first beat of a row.
- DOUT  out  OP_CHANNEL_WIDTH  last completed row.
- done  out  1  one-cycle strobe; DOUT has just been updated.
- busy  out  1  a partial row is being collected (beat count > 0).
- res_out  out  2  resolution latched for the row currently on DOUT.

## Operation
- Two states: IDLE (beat count 0) and COLLECT (1 ≤ count < steps).
- IDLE, valid=1:
  - latch imageResolution into row_res and set steps = stepSel for row_res.
  - store beat 0; count becomes 1, or the row completes immediately if steps==1.
- COLLECT, valid=1: store beat k = count, then count+1.
- Bit mapping for beat k, lane i: asm[i*steps + k] = DIN[i], for i in 0..IP_CHANNEL_WIDTH-1.
  - This matches the serializer exactly.
  - Bits at or above IP_CHANNEL_WIDTH*steps are zero in the completed row.
- valid=0: no state change. Gaps of any length between beats are legal.
- Row completion, when the beat with k = steps-1 is accepted:
  - DOUT ← completed row, with unused upper bits forced to 0.
  - res_out ← row_res.
  - done=1 for exactly one cycle.
  - count → 0 and the assembly buffer is cleared.
- Double buffering: DOUT and res_out hold their value until the next row completes. Collecting the next row never disturbs DOUT.
- imageResolution changes while in COLLECT are ignored until the next row starts.
- clear=1:
  - count → 0, assembly buffer → 0, state → IDLE.
  - DOUT and res_out are unchanged; done is not asserted.
  - clear wins over a simultaneous valid, and that beat is discarded.
- clear=1 on the cycle a row would complete: that row is discarded and done stays 0.

## Timing
- Reset values: DOUT=0, done=0, busy=0, res_out=2'b00, count=0, assembly buffer=0.
- Latency: if the final beat is sampled at edge N, DOUT, res_out and done are valid after edge N. done falls after edge N+1 unless another row completes.
- Throughput: one beat per cycle. A row needs exactly `steps` valid cycles. Back-to-back rows have no bubble.
  - valid may be high in the cycle done is high; that beat is beat 0 of the next row.
- busy is registered: 1 after any edge that leaves count > 0, 0 otherwise.
- rst asserted mid-row clears all state immediately, without waiting for a clock edge. The first valid after rst deasserts is beat 0.

## Test plan
- Reset, then imageResolution=01, 32 valid beats from the serializer of row R=640'h0123…cdef (repeated pattern):
  - expect DOUT[639:0]==R, DOUT[1079:640]==0, res_out=01;
  - done high exactly one cycle, after the 32nd beat's edge.
- Resolution 00 and 10, 16 and 54 beats of an all-ones row: expect DOUT low 320 bits set (upper zero), then all 1080 bits set. res_out 00, then 10.
- Interleaved gaps: 32 beats with valid toggling 1,0,0,1…: expect the same DOUT as the gap-free case. busy is 1 from beat 1 until completion.
- clear after beat 10 of a 32-beat row, with a prior DOUT=A:
  - DOUT stays A, no done;
  - the next 32 beats of row B give DOUT=B.
  - Also check clear and valid together on beat 31: no done.
- Back-to-back rows A,B with valid held high 64 cycles: done pulses at beats 32 and 64. DOUT=A between the pulses, then B.
- rst pulsed (async, mid-cycle) after beat 20: DOUT=0, busy=0 immediately. A fresh 32-beat row then completes correctly.
